nibble_add_seq: RTL and testbench

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

---
 rtl/nibble_add_seq_pkg.sv | 12 +
 rtl/nibble_add_seq_cla4.sv | 32 +++
 rtl/nibble_add_seq.sv | 128 ++++++++++++
 tb/tb_nibble_add_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_seq_pkg.sv
// rtl/nibble_add_seq_pkg.sv - shared state encoding and slice width for nibble_add_seq
package nibble_add_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

endpackage

// File: rtl/nibble_add_seq_cla4.sv
// rtl/nibble_add_seq_cla4.sv - 4-bit carry-lookahead slice with carry-in
// c3 is exposed so the top can form signed overflow on the MSB slice.
module cla4_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s    = w_p ^ w_c[3:0];
  assign c3   = w_c[3];
  assign cout = w_c[4];

endmodule

// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - nibble-serial adder/subtractor, one CLA slice per RUN cycle
// Subtraction is A + ~B + 1: B is inverted at accept and the carry register seeded with op_sub.
module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SLICE_W*NIBBLES-1:0]   op_a,
  input  logic [SLICE_W*NIBBLES-1:0]   op_b,
  input  logic                         op_sub,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SLICE_W*NIBBLES-1:0]   result,
  output logic                         carry,
  output logic                         ovf,
  output logic                         busy
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_cy;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_result;
  logic               r_carry;
  logic               r_ovf;
  logic               r_out_valid;

  logic [IDX_W+1:0]   w_base;
  logic [3:0]         w_s;
  logic               w_c3;
  logic               w_cout;
  logic               w_last;

  assign w_base = {r_idx, 2'b00};
  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  cla4_cin u_cla (
    .a    (r_a[w_base +: SLICE_W]),
    .b    (r_b[w_base +: SLICE_W]),
    .cin  (r_cy),
    .s    (w_s),
    .c3   (w_c3),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN,
      ST_DONE: busy     = 1'b1;
      default: ;
    endcase
  end

  // Datapath; result keeps its old value outside RUN and is overwritten one nibble per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_cy        <= 1'b0;
      r_idx       <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a   <= op_a;
            r_b   <= op_b ^ {W{op_sub}};
            r_cy  <= op_sub;
            r_idx <= '0;
          end
        end
        ST_RUN: begin
          r_result[w_base +: SLICE_W] <= w_s;
          r_cy  <= w_cout;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_carry     <= w_cout;
            r_ovf       <= w_c3 ^ w_cout;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb/tb_nibble_add_seq.sv - scoreboard bench for nibble_add_seq with a behavioural arithmetic model
module tb_nibble_add_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         op_sub    = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] op_a      = '0;
  logic [W-1:0] op_b      = '0;
  logic         in_ready;
  logic         out_valid;
  logic         carry;
  logic         ovf;
  logic         busy;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  int   issued = 0;

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t        e;
    longint      mod;
    longint      ua;
    longint      ub;
    longint      sum;
    longint      sa;
    longint      sbv;
    longint      sr;
    mod = longint'(1) << W;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = (ua >= mod / 2) ? ua - mod : ua;
    sbv = (ub >= mod / 2) ? ub - mod : ub;
    if (!sub) begin
      sum = ua + ub;
      e.c = (sum >= mod);
      sr  = sa + sbv;
    end else begin
      sum = ua - ub + mod;
      e.c = (ua >= ub);
      sr  = sa - sbv;
    end
    e.res = W'(sum % mod);
    e.v   = (sr >= mod / 2) || (sr < -(mod / 2));
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    sb.push_back(model(a, b, sub));
    issued++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("carry", carry, e.c);
        chk("ovf", ovf, e.v);
        popped++;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  // Issue one operation; called and returns just after a falling edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input bit rand_or, input int stall, input bit bp_check);
    int   n;
    exp_t e;
    e = model(a, b, sub);
    wait_ready();
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    push_exp(a, b, sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end while (!out_valid && n < 50);
    chk("latency_edges_after_accept", n, NIBBLES);
    out_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bp_check) begin
        chk("bp_out_valid", out_valid, 1);
        chk("bp_result_stable", result, e.res);
        chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    if (bp_check) begin
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_idle_out_valid", out_valid, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int t;
    int t0;
    int gap;
    int bad;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_carry", carry, 0);
    chk("reset_ovf", ovf, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_busy", busy, 0);

    issue(16'h0001, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    issue(16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b0);
    issue(16'h8000, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
    issue(16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1'b0);

    issue(16'hA5C3, 16'h1F2E, 1'b0, 1'b0, 10, 1'b1);

    // Busy masking: in_valid stays high with changing operands.
    wait_ready();
    out_ready = 1'b1;
    op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'($urandom);
    in_valid = 1'b1;
    acc = 0; t = 0; t0 = 0; gap = 0;
    while (acc < 2 && t < 100) begin
      if (in_ready) begin
        push_exp(op_a, op_b, op_sub);
        acc++;
        if (acc == 1) t0 = t;
        else gap = t - t0;
      end else begin
        op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'($urandom);
      end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    chk("mask_accept_count", acc, 2);
    chk("mask_issue_interval", gap, NIBBLES + 2);
    t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mask_drain", sb.size(), 0);

    // Reset mid-RUN.
    wait_ready();
    op_a = 16'hBEEF; op_b = 16'h1357; op_sub = 1'b0; in_valid = 1'b1;
    push_exp(op_a, op_b, op_sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_run_out_valid", out_valid, 0);
    chk("rst_run_result", result, 0);
    chk("rst_run_carry", carry, 0);
    chk("rst_run_ovf", ovf, 0);
    chk("rst_run_busy", busy, 0);
    chk("rst_run_in_ready", in_ready, 1);
    void'(sb.pop_back());
    issued--;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("rst_run_no_out_valid", bad, 0);
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1, $urandom_range(0, 3), 1'b0);
    end

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_empty", sb.size(), 0);
    chk("transactions_seen", popped, issued);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
